// File: rtl/bt_unit_pipe_if.sv
// Handshake bundle for the butterfly pipeline: operand beat in, result beat out.
// The master drives operands and out_ready; the slave (the pipeline) drives results.
interface bt_unit_pipe_if #(
    parameter int bit_len = 23
) ();
    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic [bit_len-1:0] A_in;
    logic [bit_len-1:0] B_in;
    logic [bit_len-1:0] zeta;
    logic               out_valid;
    logic               out_ready;
    logic [bit_len-1:0] A_out;
    logic [bit_len-1:0] B_out;
    logic               out_mode;

    modport master (
        output in_valid, mode, A_in, B_in, zeta, out_ready,
        input  in_ready, out_valid, A_out, B_out, out_mode
    );

    modport slave (
        input  in_valid, mode, A_in, B_in, zeta, out_ready,
        output in_ready, out_valid, A_out, B_out, out_mode
    );
endinterface

// File: rtl/bt_unit_pipe.sv
// Four-stage modular NTT butterfly (CT forward / GS inverse), one beat per cycle.
// Optional macro BT_UNIT_PIPE_HALF_EN halves both GS results modulo Q.
module bt_unit_pipe #(
    parameter int bit_len = 23,
    parameter int Q       = 8380417
) (
    input  logic           clk,
    input  logic           reset,
    bt_unit_pipe_if.slave  bus
);
    localparam int W  = bit_len;
    localparam int PW = 2 * bit_len;
    localparam logic [W:0]    q_e = (W+1)'(Q);
    localparam logic [PW-1:0] q_p = PW'(Q);

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= q_e) begin
            s = s - q_e;
        end
        return s[W-1:0];
    endfunction

    // Borrow case adds Q first so the result stays a non-negative representative.
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        if (a >= b) begin
            d = {1'b0, a} - {1'b0, b};
        end else begin
            d = {1'b0, a} + q_e - {1'b0, b};
        end
        return d[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_half(input logic [W-1:0] x);
        logic [W:0] h;
        if (x[0]) begin
            h = ({1'b0, x} + q_e) >> 1;
        end else begin
            h = {1'b0, x} >> 1;
        end
        return h[W-1:0];
    endfunction

    logic            adv_s;
    logic [W-1:0]    s1_a_s, s1_x_s;
    logic            s1_valid_r, s1_mode_r;
    logic [W-1:0]    s1_a_r, s1_x_r, s1_z_r;
    logic            s2_valid_r, s2_mode_r;
    logic [W-1:0]    s2_a_r;
    logic [PW-1:0]   s2_prod_r;
    logic [PW-1:0]   s3_red_s;
    logic            s3_valid_r, s3_mode_r;
    logic [W-1:0]    s3_a_r, s3_t_r;
    logic [W-1:0]    res_a_s, res_b_s;
    logic            out_valid_r, out_mode_r;
    logic [W-1:0]    a_out_r, b_out_r;

    assign adv_s         = !out_valid_r || bus.out_ready;
    assign bus.in_ready  = adv_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_mode  = out_mode_r;
    assign bus.A_out     = a_out_r;
    assign bus.B_out     = b_out_r;

    // Stage 1 operands: CT multiplies B and carries A; GS multiplies (A-B) and carries A+B.
    always_comb begin
        s1_a_s = bus.A_in;
        s1_x_s = bus.B_in;
        if (bus.mode) begin
            s1_a_s = mod_add(bus.A_in, bus.B_in);
            s1_x_s = mod_sub(bus.A_in, bus.B_in);
        end else begin
            s1_a_s = bus.A_in;
            s1_x_s = bus.B_in;
        end
    end

    // Stage 3 exact reduction of the full-width product.
    always_comb begin
        s3_red_s = s2_prod_r % q_p;
    end

    // Final combine: CT forms A+t / A-t, GS passes the sum and reduced product through.
    always_comb begin
        res_a_s = s3_a_r;
        res_b_s = s3_t_r;
        if (s3_mode_r) begin
`ifdef BT_UNIT_PIPE_HALF_EN
            res_a_s = mod_half(s3_a_r);
            res_b_s = mod_half(s3_t_r);
`else
            res_a_s = s3_a_r;
            res_b_s = s3_t_r;
`endif
        end else begin
            res_a_s = mod_add(s3_a_r, s3_t_r);
            res_b_s = mod_sub(s3_a_r, s3_t_r);
        end
    end

    // Pipeline registers; every stage holds together while the output is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s1_mode_r   <= 1'b0;
            s1_a_r      <= '0;
            s1_x_r      <= '0;
            s1_z_r      <= '0;
            s2_valid_r  <= 1'b0;
            s2_mode_r   <= 1'b0;
            s2_a_r      <= '0;
            s2_prod_r   <= '0;
            s3_valid_r  <= 1'b0;
            s3_mode_r   <= 1'b0;
            s3_a_r      <= '0;
            s3_t_r      <= '0;
            out_valid_r <= 1'b0;
            out_mode_r  <= 1'b0;
            a_out_r     <= '0;
            b_out_r     <= '0;
        end else if (adv_s) begin
            s1_valid_r  <= bus.in_valid;
            s1_mode_r   <= bus.mode;
            s1_a_r      <= s1_a_s;
            s1_x_r      <= s1_x_s;
            s1_z_r      <= bus.zeta;
            s2_valid_r  <= s1_valid_r;
            s2_mode_r   <= s1_mode_r;
            s2_a_r      <= s1_a_r;
            s2_prod_r   <= {{W{1'b0}}, s1_x_r} * {{W{1'b0}}, s1_z_r};
            s3_valid_r  <= s2_valid_r;
            s3_mode_r   <= s2_mode_r;
            s3_a_r      <= s2_a_r;
            s3_t_r      <= s3_red_s[W-1:0];
            out_valid_r <= s3_valid_r;
            out_mode_r  <= s3_mode_r;
            a_out_r     <= res_a_s;
            b_out_r     <= res_b_s;
        end
    end
endmodule

// File: tb/tb_bt_unit_pipe.sv
// Randomized scoreboard bench for bt_unit_pipe against an arithmetic reference model.
module tb_bt_unit_pipe;
    localparam int    BL = 23;
    localparam longint QM = 8380417;

    typedef struct {
        bit     m;
        longint a;
        longint b;
        int     acc;
        bit     dc;
    } exp_t;

    logic clk;
    logic reset;
    int   chk_cnt;
    int   pass_cnt;
    int   cyc;
    int   last_stall;
    bit   prev_stall;
    logic [BL-1:0] held_a, held_b;
    logic held_m;
    bit   rdy_rand;
    bit   rdy_force_low;
    exp_t sb[$];

    bt_unit_pipe_if #(.bit_len(BL)) bus ();

    bt_unit_pipe #(.bit_len(BL), .Q(8380417)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        chk_cnt++;
        if (act == req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void model(input bit m, input longint a, input longint b, input longint z,
                                  output longint ea, output longint eb);
        longint t;
        if (!m) begin
            t  = (b * z) % QM;
            ea = (a + t) % QM;
            eb = (a - t + QM) % QM;
        end else begin
            ea = (a + b) % QM;
            eb = (((a - b + QM) % QM) * z) % QM;
`ifdef BT_UNIT_PIPE_HALF_EN
            ea = (ea * ((QM + 1) / 2)) % QM;
            eb = (eb * ((QM + 1) / 2)) % QM;
`endif
        end
    endfunction

    // Drive one beat and hold it until accepted; push the expectation on acceptance.
    task automatic send_beat(input bit m, input longint a, input longint b, input longint z,
                             input longint ea, input longint eb, input bit dc);
        bit   done;
        exp_t e;
        done = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.A_in     = BL'(a);
        bus.B_in     = BL'(b);
        bus.zeta     = BL'(z);
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.m = m; e.a = ea; e.b = eb; e.acc = cyc; e.dc = dc;
                sb.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic send_rand(input bit m);
        longint a, b, z, ea, eb;
        a = longint'($urandom_range(32'(QM - 1)));
        b = longint'($urandom_range(32'(QM - 1)));
        z = longint'($urandom_range(32'(QM - 1)));
        model(m, a, b, z, ea, eb);
        send_beat(m, a, b, z, ea, eb, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.A_in     = BL'($urandom);
            bus.B_in     = BL'($urandom);
        end
    endtask

    task automatic wait_drain();
        idle(1);
        for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
        check("drain_empty", sb.size(), 0);
    endtask

    // Output ready generator.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_force_low)  bus.out_ready = 1'b0;
            else if (rdy_rand)  bus.out_ready = ($urandom_range(3) != 0);
            else                bus.out_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each consumed result, checks stall stability and latency.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_eq_adv", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_A_out", bus.A_out, held_a);
                check("hold_B_out", bus.B_out, held_b);
                check("hold_mode", bus.out_mode, held_m);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    if (!e.dc) begin
                        check("A_out", bus.A_out, e.a);
                        check("B_out", bus.B_out, e.b);
                    end
                    check("out_mode", bus.out_mode, e.m);
                    if (last_stall < e.acc) check("latency", cyc - e.acc, 4);
                end
            end
            if (bus.out_valid && !bus.out_ready) last_stall = cyc;
            prev_stall = bus.out_valid && !bus.out_ready;
            held_a = bus.A_out;
            held_b = bus.B_out;
            held_m = bus.out_mode;
        end
    end

    initial begin
        chk_cnt = 0; pass_cnt = 0; cyc = 0; last_stall = -1; prev_stall = 1'b0;
        rdy_rand = 1'b0; rdy_force_low = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.mode = 1'b0;
        bus.A_in = '0; bus.B_in = '0; bus.zeta = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_A_out", bus.A_out, 0);
        check("rst_B_out", bus.B_out, 0);
        check("rst_out_mode", bus.out_mode, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Known vectors.
        send_beat(1'b0, 1, 2, 3, 7, 8380412, 1'b0);
`ifdef BT_UNIT_PIPE_HALF_EN
        send_beat(1'b1, 1, 2, 3, 4190210, 4190207, 1'b0);
`else
        send_beat(1'b1, 1, 2, 3, 3, 8380414, 1'b0);
`endif
        send_beat(1'b0, 8380416, 8380416, 8380416, 0, 8380415, 1'b0);
        send_beat(1'b0, 12345, 999, 0, 12345, 12345, 1'b0);
        wait_drain();

        // 16 back-to-back beats, alternating mode.
        for (int i = 0; i < 16; i++) send_rand(i[0]);
        wait_drain();

        // Fill the pipe with output blocked, hold it, then drain.
        rdy_force_low = 1'b1;
        for (int i = 0; i < 4; i++) send_rand(i[1]);
        idle(4);
        @(negedge clk);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_in_flight", sb.size(), 4);
        rdy_force_low = 1'b0;
        wait_drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) send_rand(i[0]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_A_out", bus.A_out, 0);
        check("mid_rst_B_out", bus.B_out, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        idle(10);

        // Randomized traffic with bubbles, backpressure and out-of-range operands.
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(9));
            if (r == 0) begin
                idle(1);
            end else if (r == 1) begin
                send_beat(1'($urandom), QM + longint'($urandom_range(8000)),
                          longint'($urandom_range(32'(QM - 1))),
                          QM + longint'($urandom_range(8000)), 0, 0, 1'b1);
            end else begin
                send_rand(1'($urandom));
            end
        end
        rdy_rand = 1'b0;
        wait_drain();
        idle(5);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/bt_unit_pipe.md
BT_UNIT_PIPE -- requirements
Module: bt_unit_pipe

Interface
REQ-001 SHALL have parameter bit_len, default 23: coefficient/twiddle width.
REQ-002 SHALL have parameter Q, default 8380417: odd prime modulus, Q < 2^bit_len.
REQ-003 SHALL have clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have mode  input  1: 0 = CT (forward NTT) butterfly, 1 = GS (inverse NTT) butterfly; sampled with input beat.
REQ-006 SHALL have in_valid  input  1: A_in/B_in/zeta/mode valid this cycle.
REQ-007 SHALL have in_ready  output  1: block can accept a beat this cycle.
REQ-008 SHALL have A_in, B_in, zeta  input  bit_len each: unsigned operands in [0, Q-1].
REQ-009 SHALL have out_valid  output  1: A_out/B_out/out_mode hold a result.
REQ-010 SHALL have out_ready  input  1: downstream accepts result this cycle.
REQ-011 SHALL have A_out, B_out  output  bit_len each: unsigned results in [0, Q-1].
REQ-012 SHALL have out_mode  output  1: mode of the beat currently on A_out/B_out.

Function
REQ-013 A beat SHALL be accepted when in_valid && in_ready; a result SHALL be consumed when out_valid && out_ready.
REQ-014 CT: t = (B*zeta) mod Q; A_out = (A+t) mod Q; B_out = (A-t) mod Q.
REQ-015 GS: A_out = (A+B) mod Q; B_out = (((A-B) mod Q)*zeta) mod Q.
REQ-016 All reductions SHALL be exact (full 2*bit_len-bit product, no truncation); subtraction results SHALL be non-negative representatives.
REQ-017 Pipeline SHALL be 4 stages; accepted beat appears on outputs with out_valid exactly 4 cycles after acceptance when unstalled, for both modes.
REQ-018 Throughput SHALL be one beat per cycle; beats SHALL exit in acceptance order with their own mode.
REQ-019 Advance condition adv = !out_valid || out_ready; in_ready SHALL equal adv (combinational).
REQ-020 When adv = 0 all stages SHALL hold; A_out/B_out/out_mode/out_valid SHALL stay stable; no beat lost or duplicated.
REQ-021 Bubbles (in_valid = 0 while adv = 1) SHALL propagate as invalid stages and never assert out_valid.
REQ-022 Mode change between consecutive beats SHALL require no idle cycle.
REQ-023 Operands >= Q yield unspecified data values but SHALL NOT disturb handshake or other beats.

Reset
REQ-024 While reset = 1 at a clock edge, all stage-valid flags, out_valid, A_out, B_out, out_mode SHALL become 0.
REQ-025 Reset mid-operation SHALL discard all in-flight beats; no result of a pre-reset beat appears afterwards.
REQ-026 in_ready SHALL be 1 in the cycle after reset deasserts (pipeline empty).

Configuration
REQ-027 Macro BT_UNIT_PIPE_HALF_EN defined: GS-mode results A_out and B_out SHALL each be multiplied by 2^-1 mod Q (x even -> x/2, x odd -> (x+Q)/2) within the same 4-cycle latency; CT unaffected.
REQ-028 Macro BT_UNIT_PIPE_HALF_EN undefined: no halving logic; GS results exactly per REQ-015.

Verification (Q = 8380417, bit_len = 23)
REQ-029 CT, A=1, B=2, zeta=3 -> 4 cycles later A_out=7, B_out=8380412, out_mode=0.
REQ-030 GS, A=1, B=2, zeta=3 -> A_out=3, B_out=8380414 (HALF_EN: A_out=4190210, B_out=4190207).
REQ-031 CT, A=B=zeta=8380416 -> A_out=0, B_out=8380415; zeta=0 -> A_out=B_out=A.
REQ-032 16 back-to-back beats, alternating mode, out_ready=1 -> first result cycle 4, last cycle 19, in order, each matches golden model.
REQ-033 Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, outputs held constant, then all 4 in-flight results drain in order with none lost.
REQ-034 reset=1 for one cycle with 3 beats in flight -> next cycle out_valid=0, A_out=B_out=0; no stale result ever emitted; in_ready=1 after release.
